// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: VGA text-mode timing, incremental cell tracking, font-fetch
// addressing and latency-aligned colour/sync output with blinking underline cursor.
module vga_text_ctrl #(
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter int SYNC_POL     = 0,
   parameter int CHAR_W       = 9,
   parameter int CHAR_H       = 16,
   parameter int COLS         = 70,
   parameter int ROWS         = 30,
   parameter int LAT          = 2,
   parameter int BLINK_FRAMES = 30
) (
   input  logic        pclk,
   input  logic        reset,
   output logic [6:0]  char_col,
   output logic [4:0]  char_row,
   output logic [3:0]  glyph_x,
   output logic [3:0]  glyph_y,
   output logic        addr_valid,
   input  logic        glyph_bit,
   input  logic [23:0] fg_color,
   input  logic [23:0] bg_color,
   input  logic        cursor_en,
   input  logic [6:0]  cursor_col,
   input  logic [4:0]  cursor_row,
   output logic        hsync,
   output logic        vsync,
   output logic        valid,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int FW = $clog2(BLINK_FRAMES) + 1;
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_TXT  = HW'(COLS * CHAR_W);
   localparam logic [HW-1:0] HS_ON  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_TXT  = VW'(ROWS * CHAR_H);
   localparam logic [VW-1:0] VS_ON  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [3:0]    GX_LAST = 4'(CHAR_W - 1);
   localparam logic [3:0]    GY_LAST = 4'(CHAR_H - 1);
   localparam logic [3:0]    GY_UL   = (CHAR_H >= 2) ? 4'(CHAR_H - 2) : 4'd0;
   localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);
   localparam logic          SP      = 1'(SYNC_POL);

   logic [HW-1:0] r_h_cnt;
   logic [VW-1:0] r_v_cnt;
   logic [3:0]    r_gx, r_gy;
   logic [6:0]    r_col;
   logic [4:0]    r_row;
   logic [FW-1:0] r_frm;
   logic          r_blink;
   logic [5:0]    r_dly [LAT];
   logic          w_h_end, w_v_end, w_av, w_vis, w_hit;
   logic [5:0]    w_flags, w_o;
   logic [23:0]   w_rgb;

   assign w_h_end = r_h_cnt == H_LAST;
   assign w_v_end = r_v_cnt == V_LAST;
   assign w_av    = (r_h_cnt < H_TXT) & (r_v_cnt < V_TXT);
   assign w_vis   = (r_h_cnt < H_VIS) & (r_v_cnt < V_VIS);
   assign w_hit   = cursor_en & r_blink & w_av & (r_col == cursor_col) &
                    (r_row == cursor_row) & (r_gy >= GY_UL);
   // Flag order: {frame_start, cursor hit, addr_valid, visible, vsync, hsync}, active-high.
   assign w_flags = {(r_h_cnt == '0) & (r_v_cnt == '0), w_hit, w_av, w_vis,
                     (r_v_cnt >= VS_ON) & (r_v_cnt < VS_OFF),
                     (r_h_cnt >= HS_ON) & (r_h_cnt < HS_OFF)};
   assign w_o     = r_dly[LAT-1];
   assign w_rgb   = !w_o[2] ? 24'h0 : !w_o[3] ? bg_color :
                    (w_o[4] | glyph_bit) ? fg_color : bg_color;

   assign addr_valid = w_av;
   assign char_col   = w_av ? r_col : '0;
   assign char_row   = w_av ? r_row : '0;
   assign glyph_x    = w_av ? r_gx : '0;
   assign glyph_y    = w_av ? r_gy : '0;

   always_ff @(posedge pclk) begin
      if (reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
         r_gx    <= '0;
         r_col   <= '0;
         r_gy    <= '0;
         r_row   <= '0;
         r_frm   <= '0;
         r_blink <= 1'b0;
      end else begin
         r_h_cnt <= w_h_end ? '0 : r_h_cnt + 1'b1;
         if (w_h_end) begin
            r_gx  <= '0;
            r_col <= '0;
         end else if (r_h_cnt < H_VIS) begin
            r_gx <= (r_gx == GX_LAST) ? '0 : r_gx + 1'b1;
            if (r_gx == GX_LAST) r_col <= r_col + 1'b1;
         end
         if (w_h_end) begin
            r_v_cnt <= w_v_end ? '0 : r_v_cnt + 1'b1;
            if (w_v_end) begin
               r_gy    <= '0;
               r_row   <= '0;
               r_frm   <= (r_frm == F_LAST) ? '0 : r_frm + 1'b1;
               r_blink <= r_blink ^ (r_frm == F_LAST);
            end else if (r_v_cnt < V_VIS) begin
               r_gy <= (r_gy == GY_LAST) ? '0 : r_gy + 1'b1;
               if (r_gy == GY_LAST) r_row <= r_row + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) r_dly[i] <= '0;
      end else begin
         r_dly[0] <= w_flags;
         for (int i = 1; i < LAT; i++) r_dly[i] <= r_dly[i-1];
      end
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         hsync                 <= ~SP;
         vsync                 <= ~SP;
         valid                 <= 1'b0;
         frame_start           <= 1'b0;
         {vga_r, vga_g, vga_b} <= '0;
      end else begin
         hsync                 <= w_o[0] ~^ SP;
         vsync                 <= w_o[1] ~^ SP;
         valid                 <= w_o[2];
         frame_start           <= w_o[5];
         {vga_r, vga_g, vga_b} <= w_rgb;
      end
   end
endmodule

// File: tb/tb_vga_text_ctrl.sv
// tb_vga_text_ctrl: three configurations driven with random glyph/colour/cursor
// inputs, checked every cycle against an arithmetic model of position-since-reset.
module tb_vga_text_ctrl;
   typedef struct packed {
      int ha, hf, hs, hb, va, vf, vs, vb, cw, ch, cols, rows, lat, bf, sp;
   } cfg_t;

   localparam cfg_t C_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 9, 16, 70, 30, 2, 30, 0};
   localparam cfg_t C_SM  = '{16, 2, 3, 3, 8, 1, 1, 1, 3, 3, 5, 2, 4, 2, 1};
   localparam cfg_t C_L1  = '{16, 1, 2, 1, 8, 1, 2, 1, 4, 1, 4, 8, 1, 1, 0};

   logic        pclk = 1'b0;
   logic        reset = 1'b1;
   logic        glyph_bit = 1'b0;
   logic [23:0] fg = '0, bg = '0;
   logic        cen = 1'b1;
   logic [6:0]  ccol = 7'd1;
   logic [4:0]  crow = 5'd0;

   logic [6:0]  col [3];
   logic [4:0]  row [3];
   logic [3:0]  gx [3], gy [3];
   logic        av [3], hs [3], vs [3], vld [3], fs [3];
   logic [7:0]  r [3], g [3], b [3];

   logic        h_g [4096];
   logic [23:0] h_fg [4096], h_bg [4096];
   logic        h_cen [4096];
   logic [6:0]  h_ccol [4096];
   logic [4:0]  h_crow [4096];

   int t = 0;
   int n_chk = 0;
   int n_pass = 0;

   always #5 pclk = ~pclk;

   vga_text_ctrl u_def (
      .pclk(pclk), .reset(reset), .char_col(col[0]), .char_row(row[0]),
      .glyph_x(gx[0]), .glyph_y(gy[0]), .addr_valid(av[0]), .glyph_bit(glyph_bit),
      .fg_color(fg), .bg_color(bg), .cursor_en(cen), .cursor_col(ccol),
      .cursor_row(crow), .hsync(hs[0]), .vsync(vs[0]), .valid(vld[0]),
      .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]), .frame_start(fs[0]));

   vga_text_ctrl #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(8), .V_FP(1),
      .V_SYNC(1), .V_BP(1), .SYNC_POL(1), .CHAR_W(3), .CHAR_H(3), .COLS(5),
      .ROWS(2), .LAT(4), .BLINK_FRAMES(2)
   ) u_sm (
      .pclk(pclk), .reset(reset), .char_col(col[1]), .char_row(row[1]),
      .glyph_x(gx[1]), .glyph_y(gy[1]), .addr_valid(av[1]), .glyph_bit(glyph_bit),
      .fg_color(fg), .bg_color(bg), .cursor_en(cen), .cursor_col(ccol),
      .cursor_row(crow), .hsync(hs[1]), .vsync(vs[1]), .valid(vld[1]),
      .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]), .frame_start(fs[1]));

   vga_text_ctrl #(
      .H_ACTIVE(16), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(8), .V_FP(1),
      .V_SYNC(2), .V_BP(1), .SYNC_POL(0), .CHAR_W(4), .CHAR_H(1), .COLS(4),
      .ROWS(8), .LAT(1), .BLINK_FRAMES(1)
   ) u_l1 (
      .pclk(pclk), .reset(reset), .char_col(col[2]), .char_row(row[2]),
      .glyph_x(gx[2]), .glyph_y(gy[2]), .addr_valid(av[2]), .glyph_bit(glyph_bit),
      .fg_color(fg), .bg_color(bg), .cursor_en(cen), .cursor_col(ccol),
      .cursor_row(crow), .hsync(hs[2]), .vsync(vs[2]), .valid(vld[2]),
      .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]), .frame_start(fs[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
   endtask

   // Address stage: {addr_valid, col, row, glyph_x, glyph_y} of pixel t.
   function automatic logic [20:0] m_addr(input cfg_t c, input int tt);
      int ht = c.ha + c.hf + c.hs + c.hb;
      int vt = c.va + c.vf + c.vs + c.vb;
      int h = tt % ht;
      int v = (tt / ht) % vt;
      if (h < c.cols * c.cw && v < c.rows * c.ch)
         return {1'b1, 7'(h / c.cw), 5'(v / c.ch), 4'(h % c.cw), 4'(v % c.ch)};
      return 21'h0;
   endfunction

   // Output stage: {hsync, vsync, valid, frame_start, rgb} seen in cycle t.
   function automatic logic [27:0] m_out(input cfg_t c, input int tt);
      int ht = c.ha + c.hf + c.hs + c.hb;
      int vt = c.va + c.vf + c.vs + c.vb;
      int p, h, v, fr;
      logic sp, vis, inb, hact, vact, blink, hit;
      logic [23:0] rgb;
      sp = c.sp[0];
      if (tt < c.lat + 1) return {~sp, ~sp, 2'b00, 24'h0};
      p = tt - c.lat - 1;
      h = p % ht;
      v = (p / ht) % vt;
      fr = p / (ht * vt);
      vis = h < c.ha && v < c.va;
      inb = h < c.cols * c.cw && v < c.rows * c.ch;
      hact = h >= c.ha + c.hf && h < c.ha + c.hf + c.hs;
      vact = v >= c.va + c.vf && v < c.va + c.vf + c.vs;
      blink = ((fr / c.bf) % 2) == 1;
      hit = h_cen[p] && blink && inb && (h / c.cw) == int'(h_ccol[p]) &&
            (v / c.ch) == int'(h_crow[p]) && (v % c.ch) >= c.ch - 2;
      rgb = !vis ? 24'h0 : !inb ? h_bg[tt-1] : (hit || h_g[tt-1]) ? h_fg[tt-1] : h_bg[tt-1];
      return {hact ? sp : ~sp, vact ? sp : ~sp, vis, h == 0 && v == 0, rgb};
   endfunction

   task automatic step(input logic rst_next);
      @(posedge pclk);
      t = reset ? 0 : t + 1;
      #1;
      reset = rst_next;
      glyph_bit = 1'($urandom_range(0, 1));
      fg = 24'($urandom);
      bg = 24'($urandom);
      if ($urandom_range(0, 7) == 0) begin
         cen  = $urandom_range(0, 3) != 0;
         ccol = 7'($urandom_range(0, 2));
         crow = 5'($urandom_range(0, 1));
      end
      h_g[t] = glyph_bit;
      h_fg[t] = fg;
      h_bg[t] = bg;
      h_cen[t] = cen;
      h_ccol[t] = ccol;
      h_crow[t] = crow;
      @(negedge pclk);
      chk("def_addr", 32'({av[0], col[0], row[0], gx[0], gy[0]}), 32'(m_addr(C_DEF, t)));
      chk("def_out", 32'({hs[0], vs[0], vld[0], fs[0], r[0], g[0], b[0]}), 32'(m_out(C_DEF, t)));
      chk("sm_addr", 32'({av[1], col[1], row[1], gx[1], gy[1]}), 32'(m_addr(C_SM, t)));
      chk("sm_out", 32'({hs[1], vs[1], vld[1], fs[1], r[1], g[1], b[1]}), 32'(m_out(C_SM, t)));
      chk("l1_addr", 32'({av[2], col[2], row[2], gx[2], gy[2]}), 32'(m_addr(C_L1, t)));
      chk("l1_out", 32'({hs[2], vs[2], vld[2], fs[2], r[2], g[2], b[2]}), 32'(m_out(C_L1, t)));
   endtask

   initial begin
      repeat (4) step(1'b1);
      step(1'b0);
      while (t < 1899) step(1'b0);
      step(1'b1);
      step(1'b1);
      step(1'b1);
      step(1'b0);
      repeat (2500) step(1'b0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/vga_text_ctrl.md
# vga_text_ctrl

Parametrised VGA text-mode controller for the NPC display path. It generates sync and blanking for a configurable mode and tracks character cell and glyph pixel positions incrementally, without dividers. It issues addresses to an external character-RAM/font-ROM chain with a fixed read latency and re-aligns sync, blank and pixel colour to that latency. It also adds a blinking underline cursor and a frame-start pulse.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync, back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync, back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- CHAR_W / CHAR_H, 9 / 16, glyph cell size (each 1..16)
- COLS / ROWS, 70 / 30, text grid; COLS*CHAR_W ≤ H_ACTIVE, ROWS*CHAR_H ≤ V_ACTIVE, COLS ≤ 128, ROWS ≤ 32
- LAT, 2, cycles from address out to glyph_bit in (1..4)
- BLINK_FRAMES, 30, frames per cursor blink half-period (≥1)

- pclk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- char_col  out  7  text column of current pixel (address stage)
- char_row  out  5  text row of current pixel (address stage)
- glyph_x  out  4  pixel column inside cell, 0..CHAR_W-1
- glyph_y  out  4  pixel row inside cell, 0..CHAR_H-1
- addr_valid  out  1  current pixel lies inside the text grid
- glyph_bit  in  1  font pixel, valid LAT cycles after its address
- fg_color / bg_color  in  24  {R,G,B} foreground/background colour
- cursor_en  in  1  cursor enable
- cursor_col / cursor_row  in  7 / 5  cursor cell
- hsync / vsync  out  1  sync outputs (polarity per SYNC_POL)
- valid  out  1  visible-region flag, output-aligned
- vga_r / vga_g / vga_b  out  8  pixel colour
- frame_start  out  1  one-cycle pulse with pixel (0,0) at output

## Operation
- h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of horizontal params); ordering: active, FP, sync, BP. v_cnt likewise; advances when h_cnt wraps; wraps at V_TOTAL-1.
- hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v_cnt.
- Address stage (combinational from counters): glyph_x increments each active pixel, wraps CHAR_W-1→0 with char_col+1. glyph_x and char_col clear at end of line. glyph_y increments per line while v_cnt < V_ACTIVE, wraps CHAR_H-1→0 with char_row+1. glyph_y and char_row clear at end of frame.
- addr_valid = h_cnt < COLS*CHAR_W and v_cnt < ROWS*CHAR_H. Outside that: char_col/char_row/glyph_x/glyph_y are 0.
- Cursor hit = cursor_en & blink_phase & addr_valid & cell match & glyph_y ≥ CHAR_H-2 (two-line underline).
- blink_phase toggles each BLINK_FRAMES frames; frame counter counts wraps of v_cnt.
- Delay line of depth LAT carries hsync, vsync, visible, addr_valid, cursor hit and frame-start flags.
- Colour: !visible → 0; visible & !addr_valid → bg_color; cursor hit → fg_color; otherwise glyph_bit ? fg_color : bg_color.

## Timing
- Outputs hsync, vsync, valid, vga_*, frame_start are registered. Total latency from counter position to these outputs is LAT+1 cycles. glyph_bit and colour inputs are sampled in cycle t+LAT.
- The address-stage outputs (char_col, char_row, glyph_x, glyph_y, addr_valid) are combinational from the counters, with zero latency.
- Reset state:
  - counters, cell trackers, frame counter, blink_phase = 0
  - delay line flushed to inactive
  - hsync/vsync = inactive level, valid = 0, vga_* = 0, frame_start = 0
  - address outputs reflect (0,0) with addr_valid = 1
- Reset mid-frame: the cycle after reset deasserts, counting restarts at (0,0). Outputs stay blank/inactive for LAT+1 cycles.
- Cursor inputs change asynchronously to the frame. A change is sampled per pixel, so tearing is permitted.
- End-of-line and end-of-frame on the same cycle: all trackers clear together, and frame counter and blink update in that cycle.

## Test plan
- Reset held 5 cycles, then released: hsync=vsync=1 (SYNC_POL=0), valid=0, vga_*=0 until cycle LAT+1. frame_start pulses exactly at cycle LAT+1.
- Default mode, free-run one frame: hsync period 800, low for 96 cycles starting at output of h_cnt 656. vsync low for 2 lines from line 490. valid high 640×480 per frame.
- Line 0 scan: glyph_x sequence 0..8,0..; char_col 69 at pixels 621..629. addr_valid=0 and output = bg_color for pixels 630..639.
- glyph_bit driven = bit 0 of (h_cnt delayed by LAT), fg=FFFFFF, bg=000000: output alternates white/black in the correct phase for LAT=1 and LAT=4.
- Small mode (H_ACTIVE=16, V_ACTIVE=8, BLINK_FRAMES=2), cursor_en=1 at cell (1,0): underline present only in frames 2-3, 6-7, …, on glyph_y CHAR_H-2 and CHAR_H-1.
- Reset asserted mid-line at h_cnt 300: counters restart at 0. No hsync glitch of width < H_SYNC. The next frame_start arrives LAT+1 cycles after release.
